adc_scan_ctrl: RTL and testbench

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_clkdiv.sv | 49 ++++
 rtl/adc_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan controller: FSM encoding and GAP length.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int unsigned GAP_SCLK  = 2;
    // Each sclk period is two divider ticks.
    localparam int unsigned GAP_TICKS = 2 * GAP_SCLK;

endpackage

// File: rtl/adc_clkdiv.sv
// Serial clock divider: toggles sclk every DIV clk while enabled and emits
// single-clk tick/rise/fall strobes aligned with the edge that updates sclk.
module adc_clkdiv #(
    parameter int unsigned DIV = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_sclk_en,
    output logic o_sclk,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = i_run && (r_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk <= 1'b0;
        end else if (!i_sclk_en) begin
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_sclk <= ~r_sclk;
        end
    end

    assign o_sclk = r_sclk;
    assign o_tick = w_tick;
    assign o_rise = w_tick && i_sclk_en && !r_sclk;
    assign o_fall = w_tick && i_sclk_en &&  r_sclk;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Serial ADC scan controller (single-shot or continuous channel scan).
// Optional threshold alarm enabled by defining ADC_SCAN_THRESH_EN.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DIV    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic              start,
    input  logic [ADDR_W-1:0] ch_sel,
    input  logic              adc_dout,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic              adc_din,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_ch,
    output logic              data_valid,
    output logic              busy
`ifdef ADC_SCAN_THRESH_EN
    ,
    input  logic [DATA_W-1:0] thresh,
    output logic              alarm
`endif
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned GAP_W = $clog2(GAP_TICKS);

    state_t            r_state;
    state_t            w_next;
    logic              w_launch;
    logic              w_go;
    logic              w_last_fall;
    logic              w_gap_end;
    logic              w_sclk;
    logic              w_tick;
    logic              w_rise;
    logic              w_fall;

    logic              r_busy;
    logic              r_cs_n;
    logic [ADDR_W-1:0] r_ch;
    logic [ADDR_W-1:0] r_addr_sr;
    logic [ADDR_W-1:0] r_scan_ptr;
    logic              r_scan_frame;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_data_out;
    logic [ADDR_W-1:0] r_data_ch;
    logic              r_valid;

    adc_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_run     (r_busy),
        .i_sclk_en (r_state == ST_SHIFT),
        .o_sclk    (w_sclk),
        .o_tick    (w_tick),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_go        = enable && (mode || start);
    assign w_last_fall = (r_state == ST_SHIFT) && w_fall && (r_bit == BIT_W'(DATA_W - 1));
    assign w_gap_end   = (r_state == ST_GAP) && w_tick && (r_gap == GAP_W'(GAP_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // GAP end doubles as the IDLE decision so scan frames stay exactly one GAP apart.
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_next   = ST_SHIFT;
                    w_launch = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_last_fall) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    if (enable && mode) begin
                        w_next   = ST_SHIFT;
                        w_launch = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_ch         <= '0;
            r_addr_sr    <= '0;
            r_scan_ptr   <= '0;
            r_scan_frame <= 1'b0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_gap        <= '0;
            r_data_out   <= '0;
            r_data_ch    <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                r_shift <= {r_shift[DATA_W-2:0], adc_dout};
            end
            if (w_fall) begin
                r_bit     <= r_bit + BIT_W'(1);
                r_addr_sr <= r_addr_sr << 1;
            end
            if (w_last_fall) begin
                r_cs_n     <= 1'b1;
                r_data_out <= r_shift;
                r_data_ch  <= r_ch;
                r_valid    <= 1'b1;
                r_gap      <= '0;
                r_addr_sr  <= '0;
                if (r_scan_frame) begin
                    r_scan_ptr <= (r_scan_ptr == ADDR_W'(NUM_CH - 1)) ? '0
                                                                      : r_scan_ptr + ADDR_W'(1);
                end
            end
            if ((r_state == ST_GAP) && w_tick) begin
                r_gap <= r_gap + GAP_W'(1);
            end
            if (w_gap_end) begin
                r_busy <= 1'b0;
            end
            if (w_launch) begin
                r_busy       <= 1'b1;
                r_cs_n       <= 1'b0;
                r_bit        <= '0;
                r_gap        <= '0;
                r_scan_frame <= mode;
                r_ch         <= mode ? r_scan_ptr : ch_sel;
                r_addr_sr    <= mode ? r_scan_ptr : ch_sel;
            end
        end
    end

`ifdef ADC_SCAN_THRESH_EN
    logic r_alarm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm <= 1'b0;
        end else if (w_last_fall) begin
            r_alarm <= (r_shift > thresh);
        end
    end

    assign alarm = r_alarm;
`endif

    assign adc_sclk   = w_sclk;
    assign adc_cs_n   = r_cs_n;
    assign adc_din    = r_addr_sr[ADDR_W-1];
    assign data_out   = r_data_out;
    assign data_ch    = r_data_ch;
    assign data_valid = r_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl: converter model, pin monitor and directed
// scenarios; alarm checks are added when ADC_SCAN_THRESH_EN is defined.
module tb_adc_scan_ctrl;

    localparam int unsigned DATA_W    = 10;
    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DIV       = 2;
    localparam int          FRAME_CLK = 2 * DIV * DATA_W;
    localparam int          GAP_CLK   = 4 * DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              mode = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] ch_sel = '0;
    logic              adc_dout = 1'b0;
    logic              adc_sclk;
    logic              adc_cs_n;
    logic              adc_din;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] data_ch;
    logic              data_valid;
    logic              busy;
`ifdef ADC_SCAN_THRESH_EN
    logic [DATA_W-1:0] thresh = '0;
    logic              alarm;
`endif

    adc_scan_ctrl #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DIV    (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .start      (start),
        .ch_sel     (ch_sel),
        .adc_dout   (adc_dout),
        .adc_sclk   (adc_sclk),
        .adc_cs_n   (adc_cs_n),
        .adc_din    (adc_din),
        .data_out   (data_out),
        .data_ch    (data_ch),
        .data_valid (data_valid),
        .busy       (busy)
`ifdef ADC_SCAN_THRESH_EN
        ,
        .thresh     (thresh),
        .alarm      (alarm)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Converter model: new word per frame, result bits change on sclk falls,
    // channel address captured on sclk rises.
    logic              force_en = 1'b0;
    logic [DATA_W-1:0] force_word = '0;
    logic [DATA_W-1:0] cur_word = '0;
    logic [DATA_W-1:0] din_bits = '0;
    logic              conv_cs = 1'b1;
    logic              conv_sclk = 1'b0;
    int                bitn = 0;
    logic [DATA_W-1:0] sent_q[$];
    logic [DATA_W-1:0] din_q[$];

    always @(adc_cs_n or adc_sclk) begin
        if (adc_cs_n !== conv_cs) begin
            if (adc_cs_n === 1'b0) begin
                cur_word = force_en ? force_word
                                    : DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
                sent_q.push_back(cur_word);
                bitn     = 0;
                din_bits = '0;
                adc_dout = cur_word[DATA_W-1];
            end else if (conv_cs === 1'b0) begin
                din_q.push_back(din_bits);
            end
            conv_cs = adc_cs_n;
        end
        if (adc_sclk !== conv_sclk) begin
            if (adc_cs_n === 1'b0) begin
                if (adc_sclk === 1'b1) begin
                    din_bits = {din_bits[DATA_W-2:0], adc_din};
                end else begin
                    bitn++;
                    if (bitn < DATA_W) adc_dout = cur_word[DATA_W-1-bitn];
                end
            end
            conv_sclk = adc_sclk;
        end
    end

    // Pin monitor sampled on the falling clk edge.
    int                fall_t[$];
    int                rise_t[$];
    int                bfall_t[$];
    logic [DATA_W-1:0] vdata[$];
    logic [ADDR_W-1:0] vch[$];
    logic              valarm[$];
    logic              mon_cs = 1'b1;
    logic              mon_busy = 1'b0;

    always @(negedge clk) begin
        if (mon_cs && !adc_cs_n) fall_t.push_back(cyc);
        if (!mon_cs && adc_cs_n) rise_t.push_back(cyc);
        if (mon_busy && !busy) bfall_t.push_back(cyc);
        if (data_valid) begin
            vdata.push_back(data_out);
            vch.push_back(data_ch);
`ifdef ADC_SCAN_THRESH_EN
            valarm.push_back(alarm);
`endif
        end
        mon_cs   = adc_cs_n;
        mon_busy = busy;
    end

    int b_fall = 0, b_rise = 0, b_bf = 0, b_v = 0, b_sent = 0, b_din = 0;

    task automatic mark();
        b_fall = fall_t.size();
        b_rise = rise_t.size();
        b_bf   = bfall_t.size();
        b_v    = vdata.size();
        b_sent = sent_q.size();
        b_din  = din_q.size();
    endtask

    function automatic int cnt(input int which);
        case (which)
            0:       return fall_t.size() - b_fall;
            1:       return vdata.size() - b_v;
            default: return bfall_t.size() - b_bf;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int which, input int n, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            if (cnt(which) >= n) break;
            @(negedge clk);
        end
        check(tag, cnt(which), n);
    endtask

    task automatic chk_reset(input string p);
        check({p, "_cs_n"},  adc_cs_n,   1'b1);
        check({p, "_sclk"},  adc_sclk,   1'b0);
        check({p, "_din"},   adc_din,    1'b0);
        check({p, "_dout"},  data_out,   '0);
        check({p, "_dch"},   data_ch,    '0);
        check({p, "_valid"}, data_valid, 1'b0);
        check({p, "_busy"},  busy,       1'b0);
    endtask

    function automatic logic [DATA_W-1:0] addr_word(input int ch);
        logic [DATA_W-1:0] w;
        w = DATA_W'(ch);
        return w << (DATA_W - ADDR_W);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch_r;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        mark();

        // Single conversion on channel 5 with a fixed converter word.
        mode = 1'b0; enable = 1'b1; ch_sel = 3'd5;
        force_en = 1'b1; force_word = 10'h2A5;
        @(negedge clk);
        pulse_start();
        force_en = 1'b0;
        check("s1_busy_hi", busy, 1'b1);
        check("s1_cs_lo", adc_cs_n, 1'b0);
        wait_q(1, 1, 200, "s1_valid_wait");
        wait_q(2, 1, 200, "s1_busy_wait");
        repeat (20) @(negedge clk);
        check("s1_vcount", cnt(1), 1);
        check("s1_vdata", vdata[b_v], 10'h2A5);
        check("s1_vch", vch[b_v], 3'd5);
        check("s1_data_hold", data_out, 10'h2A5);
        check("s1_din_word", din_q[b_din], 10'h280);
        check("s1_frame_len", rise_t[b_rise] - fall_t[b_fall], FRAME_CLK);
        check("s1_gap_len", bfall_t[b_bf] - rise_t[b_rise], GAP_CLK);
        check("s1_falls", cnt(0), 1);

        // Random channel; start re-pulsed and ch_sel changed during SHIFT.
        mark();
        ch_r   = int'($urandom_range(0, NUM_CH - 1));
        ch_sel = ADDR_W'(ch_r);
        pulse_start();
        ch_sel = ~ADDR_W'(ch_r);
        repeat (10) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        pulse_start();
        wait_q(2, 1, 200, "s2_busy_wait");
        repeat (30) @(negedge clk);
        check("s2_vcount", cnt(1), 1);
        check("s2_falls", cnt(0), 1);
        check("s2_vch", vch[b_v], ch_r);
        check("s2_vdata", vdata[b_v], sent_q[b_sent]);
        check("s2_din_word", din_q[b_din], addr_word(ch_r));

        // Start while disabled does nothing.
        mark();
        enable = 1'b0;
        pulse_start();
        repeat (100) @(negedge clk);
        check("s3_falls", cnt(0), 0);
        check("s3_busy", busy, 1'b0);
        check("s3_vcount", cnt(1), 0);

`ifdef ADC_SCAN_THRESH_EN
        mark();
        enable = 1'b1; thresh = 10'h200;
        force_en = 1'b1; force_word = 10'h1FF;
        pulse_start();
        wait_q(2, 1, 200, "th_busy_wait1");
        force_word = 10'h201;
        pulse_start();
        wait_q(1, 2, 200, "th_valid_wait");
        force_en = 1'b0;
        check("th_data0", vdata[b_v], 10'h1FF);
        check("th_alarm0", valarm[b_v], 1'b0);
        check("th_data1", vdata[b_v + 1], 10'h201);
        check("th_alarm1", valarm[b_v + 1], 1'b1);
        repeat (40) @(negedge clk);
`endif

        // Continuous scan after reset, enable dropped mid-way through frame 9.
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mark();
        @(negedge clk);
        mode = 1'b1; enable = 1'b1;
        wait_q(0, 9, 2000, "scan_fall_wait");
        repeat (8 * DIV + 1) @(negedge clk);
        enable = 1'b0;
        wait_q(2, 1, 400, "scan_busy_wait");
        repeat (100) @(negedge clk);
        check("scan_falls", cnt(0), 9);
        check("scan_vcount", cnt(1), 9);
        check("scan_idle_cs", adc_cs_n, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("scan_ch%0d", i), vch[b_v + i], i % NUM_CH);
            check($sformatf("scan_data%0d", i), vdata[b_v + i], sent_q[b_sent + i]);
            check($sformatf("scan_din%0d", i), din_q[b_din + i], addr_word(i % NUM_CH));
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("scan_gap%0d", i), fall_t[b_fall + i + 1] - rise_t[b_rise + i], GAP_CLK);
        end
        check("scan_busy_fall", bfall_t[b_bf] - rise_t[b_rise + 8], GAP_CLK);

        // Reset at bit 6 of a scan frame; scan restarts at channel 0.
        mark();
        enable = 1'b1;
        wait_q(0, 1, 200, "mr_fall_wait");
        repeat (12 * DIV) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("mr");
        check("mr_no_valid", cnt(1), 0);
        @(negedge clk);
        mark();
        rst_n = 1'b1;
        wait_q(1, 2, 400, "mr_valid_wait");
        enable = 1'b0;
        wait_q(2, 1, 400, "mr_busy_wait");
        check("mr_ch0", vch[b_v], 0);
        check("mr_ch1", vch[b_v + 1], 1);
        check("mr_data0", vdata[b_v], sent_q[b_sent]);
        check("mr_data1", vdata[b_v + 1], sent_q[b_sent + 1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
